rgb_mem_stage: RTL

RGB_MEM_STAGE -- requirements
Module: rgb_mem_stage

---
 rtl/rgb_mem_stage.sv | 128 ++++++++++++
 1 files changed

// File: rtl/rgb_mem_stage.sv
// Memory stage for a three-plane RGB pixel memory: one single-port access in flight, pipeline held via Stall.
// Optional REQ-state abort timer, enabled by defining RGB_MEM_TIMEOUT_EN.
module rgb_mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWrite,
    input  logic        ResultSrc,
    input  logic [1:0]  RGB,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic        Stall,
    output logic [31:0] ReadData,
    output logic        ReadValid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [17:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    // Abort fires on the REQ cycle whose miss would bring the counter to TIMEOUT.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t state;
    logic   is_load;

    logic op_request;
    logic op_valid;
    logic op_no_plane;
    logic op_conflict;

    assign op_request  = MemWrite | ResultSrc;
    assign op_valid    = op_request & (RGB != 2'b00);
    assign op_no_plane = op_request & (RGB == 2'b00);
    assign op_conflict = MemWrite & ResultSrc;

    logic unused_bits;
`ifdef RGB_MEM_TIMEOUT_EN
    logic [7:0] req_cnt;
    assign unused_bits = ^{ALUResult[31:16], WriteData[31:8]};
`else
    assign unused_bits = ^{ALUResult[31:16], WriteData[31:8], TIMEOUT_LAST};
`endif

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        Stall = 1'b0;
        case (state)
            S_IDLE:  Stall = op_valid;
            S_REQ:   Stall = 1'b1;
            default: Stall = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            is_load   <= 1'b0;
            ReadData  <= 32'h0;
            ReadValid <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 18'h0;
            mem_wdata <= 8'h0;
            err       <= 1'b0;
`ifdef RGB_MEM_TIMEOUT_EN
            req_cnt   <= 8'h0;
`endif
        end else begin
            ReadValid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        state     <= S_REQ;
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite;
                        is_load   <= ~MemWrite;
                        mem_addr  <= {RGB - 2'd1, ALUResult[15:0]};
                        mem_wdata <= WriteData[7:0];
`ifdef RGB_MEM_TIMEOUT_EN
                        req_cnt   <= 8'h0;
`endif
                        if (op_conflict) begin
                            err <= 1'b1;
                        end
                    end else if (op_no_plane) begin
                        err <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        ReadValid <= is_load;
                        state     <= S_DONE;
                        if (is_load) begin
                            ReadData <= {24'h0, mem_rdata};
                        end
                    end
`ifdef RGB_MEM_TIMEOUT_EN
                    else if (req_cnt == TIMEOUT_LAST) begin
                        mem_req   <= 1'b0;
                        ReadData  <= 32'h0;
                        ReadValid <= is_load;
                        err       <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        req_cnt <= req_cnt + 8'd1;
                    end
`endif
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
